// File: rtl/display_pkg.sv
// Shared display-mode definitions. The display controller uses the same mode constants.
package display_pkg;

  localparam int RGB_W  = 24;
  localparam int EDGE_W = 8;

  // The encoding is the raw mode code {posterize_en, display_sel}.
  typedef enum logic [2:0] {
    MODE_HALF_POST  = 3'b000,
    MODE_PASS       = 3'b100,
    MODE_FULL_SOBEL = 3'b101,
    MODE_HALF_SOBEL = 3'b110
  } mode_e;

  // Codes that are not defined decode to passthrough.
  function automatic mode_e decode_mode(input logic [2:0] code);
    case (code)
      3'b000:  return MODE_HALF_POST;
      3'b101:  return MODE_FULL_SOBEL;
      3'b110:  return MODE_HALF_SOBEL;
      default: return MODE_PASS;
    endcase
  endfunction

endpackage

// File: rtl/pixel_posterize.sv
// Posterizes one colour channel by keeping its POST_BITS MSBs and zeroing the rest.
module pixel_posterize #(
  parameter int POST_BITS = 3
) (
  input  logic [7:0] chan,
  output logic [7:0] post
);

  localparam logic [7:0] KEEP_MASK = 8'(8'hFF << (8 - POST_BITS));

  assign post = chan & KEEP_MASK;

endmodule

// File: rtl/display_mux.sv
// Two-stage output mux combining raw RGB with Sobel edge or posterized pixels by display mode.
// Define DISPLAY_MUX_SPLIT_LINE_EN to draw a white marker at the split column in half modes.
module display_mux
  import display_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int POST_BITS = 3,
  parameter int COL_W     = 11
) (
  input  logic                i_pclk,
  input  logic                i_srst,
  input  logic                i_posterize_en,
  input  logic [1:0]          i_display_sel,
  input  logic                i_valid,
  input  logic                i_sof,
  input  logic                i_eol,
  input  logic [RGB_W-1:0]    i_rgb,
  input  logic [EDGE_W-1:0]   i_edge,
  output logic                o_valid,
  output logic                o_sof,
  output logic                o_eol,
  output logic [RGB_W-1:0]    o_rgb
);

  localparam logic [COL_W-1:0] X_MAX = COL_W'(H_RES - 1);
  localparam logic [COL_W-1:0] X_MID = COL_W'(H_RES / 2);

  // x_q holds the column the next valid pixel will occupy.
  mode_e            mode_q;
  logic [COL_W-1:0] x_q;
  mode_e            cur_mode;
  logic [COL_W-1:0] cur_x;
  logic             sof_in;

  logic              s1_valid, s1_sof, s1_eol;
  logic [RGB_W-1:0]  s1_rgb;
  logic [EDGE_W-1:0] s1_edge;
  logic [COL_W-1:0]  s1_x;
  mode_e             s1_mode;

  assign sof_in = i_valid & i_sof;

  // The SOF pixel itself uses the freshly decoded mode and column 0.
  always_comb begin
    cur_mode = mode_q;
    cur_x    = x_q;
    if (sof_in) begin
      cur_mode = decode_mode({i_posterize_en, i_display_sel});
      cur_x    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_pclk) begin
    if (i_srst) begin
      mode_q   <= MODE_PASS;
      x_q      <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      s1_sof   <= i_sof;
      s1_eol   <= i_eol;
      if (i_valid) begin
        mode_q <= cur_mode;
        if (i_eol)               x_q <= '0;
        else if (cur_x == X_MAX) x_q <= X_MAX;
        else                     x_q <= cur_x + 1'b1;
      end
    end
  end

  // NOTE: pixel data registers carry no reset; s1_valid qualifies them and o_rgb is zeroed when invalid.
  always_ff @(posedge i_pclk) begin
    s1_rgb  <= i_rgb;
    s1_edge <= i_edge;
    s1_x    <= cur_x;
    s1_mode <= cur_mode;
  end

  logic [RGB_W-1:0] edge_px, post_px, mux_px;
  logic             right_half;

  assign edge_px    = {3{s1_edge}};
  assign right_half = (s1_x >= X_MID);

  pixel_posterize #(.POST_BITS(POST_BITS)) u_post_r (.chan(s1_rgb[23:16]), .post(post_px[23:16]));
  pixel_posterize #(.POST_BITS(POST_BITS)) u_post_g (.chan(s1_rgb[15:8]),  .post(post_px[15:8]));
  pixel_posterize #(.POST_BITS(POST_BITS)) u_post_b (.chan(s1_rgb[7:0]),   .post(post_px[7:0]));

  // NOTE: mux_px is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    mux_px = s1_rgb;
    case (s1_mode)
      MODE_FULL_SOBEL: mux_px = edge_px;
      MODE_HALF_SOBEL: if (right_half) mux_px = edge_px;
      MODE_HALF_POST:  if (right_half) mux_px = post_px;
      default:         mux_px = s1_rgb;
    endcase
`ifdef DISPLAY_MUX_SPLIT_LINE_EN
    if ((s1_mode == MODE_HALF_SOBEL || s1_mode == MODE_HALF_POST) && s1_x == X_MID)
      mux_px = 24'hFFFFFF;
`else
`endif
  end

  always_ff @(posedge i_pclk) begin
    if (i_srst) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_rgb   <= '0;
    end else begin
      o_valid <= s1_valid;
      o_sof   <= s1_sof;
      o_eol   <= s1_eol;
      o_rgb   <= s1_valid ? mux_px : '0;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Randomized scoreboard bench for display_mux; the reference model follows the mode/column rules directly.
module tb_display_mux;

  localparam int H_RES     = 640;
  localparam int POST_BITS = 3;
  localparam int COL_W     = 11;

  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic        posterize_en = 1'b1;
  logic [1:0]  display_sel = 2'b00;
  logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
  logic [23:0] rgb = '0;
  logic [7:0]  edge_v = '0;
  logic        o_valid, o_sof, o_eol;
  logic [23:0] o_rgb;

  display_mux #(.H_RES(H_RES), .POST_BITS(POST_BITS), .COL_W(COL_W)) dut (
    .i_pclk(clk), .i_srst(srst), .i_posterize_en(posterize_en), .i_display_sel(display_sel),
    .i_valid(valid), .i_sof(sof), .i_eol(eol), .i_rgb(rgb), .i_edge(edge_v),
    .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol), .o_rgb(o_rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    int          t;
  } exp_t;

  exp_t sb[$];

  // Reference model: the active mode, and the pixel's position in its line.
  logic [2:0] mdl_mode = 3'b100;
  int         mdl_pos = 0;
  bit         mdl_new_line = 1'b0;

  function automatic logic [7:0] post_chan(input logic [7:0] c);
    int sh = 8 - POST_BITS;
    return 8'((int'(c) >> sh) << sh);
  endfunction

  function automatic logic [23:0] expect_px(input logic [2:0] m, input int x,
                                            input logic [23:0] p, input logic [7:0] e);
    bit right = (x >= H_RES / 2);
`ifdef DISPLAY_MUX_SPLIT_LINE_EN
    if ((m == 3'b110 || m == 3'b000) && x == H_RES / 2) return 24'hFFFFFF;
`endif
    if (m == 3'b101) return {e, e, e};
    if (m == 3'b110) return right ? {e, e, e} : p;
    if (m == 3'b000) return right ? {post_chan(p[23:16]), post_chan(p[15:8]), post_chan(p[7:0])} : p;
    return p;
  endfunction

  task automatic model_pixel(input logic s, input logic l, input logic [2:0] m,
                             input logic [23:0] p, input logic [7:0] e);
    exp_t ex;
    int   x;
    if (s) mdl_mode = (m inside {3'b101, 3'b110, 3'b000}) ? m : 3'b100;
    if (s || mdl_new_line) mdl_pos = 0;
    x = (mdl_pos < H_RES) ? mdl_pos : H_RES - 1;
    ex.rgb = expect_px(mdl_mode, x, p, e);
    ex.sof = s;
    ex.eol = l;
    ex.t   = cyc + 2;
    sb.push_back(ex);
    mdl_pos++;
    mdl_new_line = l;
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [2:0] m,
                       input logic [23:0] p, input logic [7:0] e);
    @(posedge clk);
    #1;
    valid = v; sof = s; eol = l;
    {posterize_en, display_sel} = m;
    rgb = p; edge_v = e;
    if (v) model_pixel(s, l, m, p, e);
  endtask

  bit          fix_rgb = 1'b0, fix_edge = 1'b0;
  logic [23:0] fixed_rgb = '0;
  logic [7:0]  fixed_edge = '0;
  int          sw_at = -1;
  logic [2:0]  sw_m = 3'b100;

  task automatic send_line(input logic first_sof, input int len, input logic last_eol,
                           input logic [2:0] m, input int gap_pct);
    logic [23:0] p;
    logic [7:0]  e;
    logic [2:0]  mm;
    for (int i = 0; i < len; i++) begin
      while (int'($urandom_range(99)) < gap_pct)
        drive(1'b0, 1'b0, 1'b0, 3'($urandom), 24'($urandom), 8'($urandom));
      p  = fix_rgb ? fixed_rgb : 24'($urandom);
      e  = fix_edge ? fixed_edge : 8'($urandom);
      mm = (sw_at >= 0 && i >= sw_at) ? sw_m : m;
      drive(1'b1, first_sof && i == 0, last_eol && i == len - 1, mm, p, e);
    end
  endtask

  task automatic send_frame(input logic [2:0] m, input int lines, input int len, input int gap_pct);
    for (int l = 0; l < lines; l++) send_line(l == 0, len, 1'b1, m, gap_pct);
  endtask

  // Pixels already registered into the pipeline are lost when reset lands.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    srst = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0;
    while (sb.size() > 0 && sb[$].t > cyc) void'(sb.pop_back());
    mdl_mode = 3'b100; mdl_pos = 0; mdl_new_line = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        ex = sb.pop_front();
        check("latency", 32'(cyc), 32'(ex.t));
        check("rgb", 32'(o_rgb), 32'(ex.rgb));
        check("sof_eol", {30'd0, o_sof, o_eol}, {30'd0, ex.sof, ex.eol});
      end
    end else begin
      check("idle_zero", {7'd0, o_sof, o_eol, o_rgb}, 32'd0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset(3);

    // Passthrough with a constant pixel.
    fix_rgb = 1'b1; fixed_rgb = 24'h123456;
    send_frame(3'b100, 4, H_RES, 0);

    // Full Sobel with a constant edge.
    fix_edge = 1'b1; fixed_edge = 8'hA5;
    send_frame(3'b101, 2, H_RES, 10);
    fix_edge = 1'b0;

    // Half posterize on a constant pixel.
    fixed_rgb = 24'hFFE7B3;
    send_frame(3'b000, 2, H_RES, 0);
    fix_rgb = 1'b0;

    // Mode request changes mid-frame; it takes effect only at the next SOF.
    sw_at = 100; sw_m = 3'b110;
    send_frame(3'b100, 2, H_RES, 0);
    sw_at = -1;
    send_frame(3'b110, 2, H_RES, 5);

    // Overlong line without EOL saturates the column, then restarts after EOL.
    send_line(1'b1, 700, 1'b0, 3'b110, 0);
    send_line(1'b0, 5, 1'b1, 3'b110, 0);
    send_line(1'b0, H_RES, 1'b1, 3'b110, 0);

    // Reset mid-frame in full Sobel: passthrough until the next SOF.
    send_line(1'b1, 200, 1'b0, 3'b101, 0);
    do_reset(2);
    send_line(1'b0, 400, 1'b1, 3'b101, 0);
    send_frame(3'b101, 1, 50, 0);

    // Random frames over all mode codes, including one-pixel lines and mid-frame switches.
    for (int f = 0; f < 6; f++) begin
      int len;
      len   = ($urandom_range(3) == 0) ? 1 : int'($urandom_range(1, 700));
      sw_at = ($urandom_range(1) == 1) ? int'($urandom_range(0, 300)) : -1;
      sw_m  = 3'($urandom);
      send_frame(3'($urandom), int'($urandom_range(1, 3)), len, 20);
      sw_at = -1;
    end

    drive(1'b0, 1'b0, 1'b0, 3'b100, '0, '0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux.md
# display_mux

Pixel-domain output stage that sits directly downstream of the display-mode controller and upstream of the LCD/HDMI transmitter. Combines the raw RGB stream and the aligned Sobel edge stream into one output stream according to the 3-bit display mode: passthrough, full Sobel, half Sobel, or half posterize. Mode is latched only at start-of-frame so a button press never tears a frame. Fixed 2-cycle latency; no backpressure.

## Interface
- H_RES, 640: active pixels per line; split column = H_RES/2
- POST_BITS, 3: MSBs kept per colour channel in posterize (1..7)
- COL_W, 11: column counter width; must satisfy 2^COL_W > H_RES
- i_pclk  in  1  pixel clock
- i_srst  in  1  reset; one clock, synchronous, active-high
- i_posterize_en  in  1  mode bit 2 from display controller
- i_display_sel  in  2  mode bits 1:0 from display controller
- i_valid  in  1  pixel qualifier for all i_* pixel fields
- i_sof  in  1  first pixel of frame (valid with i_valid)
- i_eol  in  1  last pixel of line (valid with i_valid)
- i_rgb  in  24  raw pixel {R[23:16],G[15:8],B[7:0]}
- i_edge  in  8  Sobel magnitude, pixel-aligned with i_rgb
- o_valid, o_sof, o_eol  out  1 each  i_valid/i_sof/i_eol delayed 2 cycles
- o_rgb  out  24  composed pixel

## Operation
- Mode code m = {i_posterize_en, i_display_sel}: 3'b100 passthrough; 3'b101 full Sobel; 3'b110 half Sobel; 3'b000 half posterize; all other codes decode as passthrough.
- Active mode register: loaded from m when i_valid & i_sof; that same pixel uses the new mode. Changes of m at any other time ignored until next SOF.
- Column counter x: cleared on i_valid & i_sof and on the pixel after i_valid & i_eol; increments per valid pixel; saturates at H_RES-1 if no EOL arrives. SOF pixel has x=0.
- Per pixel: edge pixel = {e,e,e}; posterized channel c = {c[7:8-POST_BITS], (8-POST_BITS){1'b0}}.
- Full Sobel: all pixels edge. Half Sobel: x < H_RES/2 raw, else edge. Half posterize: x < H_RES/2 raw, else posterized. Passthrough: raw.
- i_valid low: counter and mode hold; o_rgb forced 0 when o_valid low.

## Timing
- Stage 1 registers pixel, flags, x, decoded mode; stage 2 registers muxed output. Input at cycle n appears at n+2 regardless of mode.
- Reset: all outputs 0, pipeline flushed, active mode = passthrough, x = 0. Reset mid-frame: pixels after reset release use passthrough until next SOF; x restarts at 0 on first valid pixel.
- SOF and EOL on same pixel (1-pixel line): mode loads, x cleared next pixel.
- Mode change coincident with SOF: new mode applies to that SOF pixel.
- Back-to-back frames with no gap supported; one pixel per clock sustained.

## Configuration
- DISPLAY_MUX_SPLIT_LINE_EN defined: in half Sobel and half posterize modes, pixel at x == H_RES/2 output as 24'hFFFFFF (visible split marker). Undefined: no marker, that pixel follows normal right-half rule. Latency identical both ways.

## Structure
- Shared package display_pkg: mode code constants (MODE_PASS 3'b100, MODE_FULL_SOBEL 3'b101, MODE_HALF_SOBEL 3'b110, MODE_HALF_POST 3'b000), RGB width 24, edge width 8; display controller imports same constants.
- One sub-module: pixel_posterize (combinational channel truncation, parameter POST_BITS), instanced three times.

## Test plan
- Reset, mode 3'b100, frame of 4 lines × H_RES, i_rgb=24'h123456 -> o_rgb=24'h123456 every pixel, o_sof/o_eol exactly 2 cycles after inputs.
- Mode 3'b101, i_edge=8'hA5 -> o_rgb=24'hA5A5A5 on all pixels.
- Mode 3'b000, POST_BITS=3, i_rgb=24'hFFE7B3 -> x<320: 24'hFFE7B3; x≥320: 24'hE0E0A0 (split marker 24'hFFFFFF at x=320 only with DISPLAY_MUX_SPLIT_LINE_EN).
- Switch mode 3'b100→3'b110 mid-frame at x=100 -> current frame stays passthrough; next frame from SOF pixel: left raw, right edge.
- Line without EOL longer than H_RES -> x saturates at 639, right-half rule holds, x=0 after next EOL.
- Assert i_srst mid-frame in mode 3'b101 -> outputs 0 during reset; after release passthrough until next SOF, then full Sobel.
